sorter_sched: RTL and testbench
===============================

Name: sorter_sched

Overview:
- Round-robin scheduler that shares one 8-bit `sorter` between NREQ requesters.
- Grants one requester and loads its word into the sorter with a one-cycle `ld` pulse.
- Collects the serial `out` bits qualified by `VO` back into a word, then returns the result with the requester id on a valid/ready handshake.
- Sits between client logic and the `sorter` instance. Adds a watchdog and a result self-check.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, sorter word width; must match the sorter's `in` width.
- TIMEOUT, 16, max idle cycles between `VO` bits before the job is aborted.

Ports:
- ck  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request; held until its gnt.
- req_data  input  NREQ*W  requester i word at [i*W +: W].
- gnt  output  NREQ  one-hot, one-cycle pulse when the word is captured.
- srt_in  output  W  to sorter `in`.
- srt_ld  output  1  to sorter `ld`.
- srt_reset  output  1  to sorter `reset`.
- srt_vo  input  1  from sorter `VO`.
- srt_out  input  1  from sorter `out`.
- res_valid  output  1  result available.
- res_data  output  W  collected word, first bit received in MSB.
- res_id  output  clog2(NREQ)  index of the granted requester.
- res_chk  output  1  1 = result is a valid sort of the input (see below).
- res_ready  input  1  consumer accepts the result.
- busy  output  1  state != IDLE.
- timeout_err  output  1  one-cycle pulse on abort.

Behaviour:
- Reset (async, any state): state = IDLE, rr pointer = 0, bit count = 0, shift register = 0.
- All outputs reset to 0, except srt_reset, which is 1 while reset is asserted.
- States: IDLE -> LOAD -> COLLECT -> PRESENT -> IDLE; COLLECT -> FLUSH -> IDLE on timeout.
- IDLE:
  - If any req is set, pick the first set bit starting at the rr pointer, wrapping at NREQ-1 -> 0.
  - Register the winner id and its word; go to LOAD next cycle.
  - If no req, stay in IDLE.
- LOAD (exactly 1 cycle):
  - srt_ld = 1, srt_in = captured word, gnt[id] = 1.
  - rr pointer = id+1 (mod NREQ).
  - Bit count = 0; watchdog = 0; go to COLLECT.
- COLLECT:
  - srt_ld = 0, srt_in holds the word.
  - Each cycle with srt_vo = 1: shift srt_out into the LSB, increment the bit count, clear the watchdog.
  - On the W-th bit, go to PRESENT on the next cycle.
  - Cycles with srt_vo = 0 increment the watchdog.
  - If the watchdog reaches TIMEOUT, go to FLUSH.
  - Extra VO bits after the W-th are ignored.
- PRESENT:
  - res_valid = 1; res_data, res_id and res_chk are stable until the handshake.
  - When res_valid && res_ready, go to IDLE; res_valid drops the next cycle.
  - New requests are not arbitrated while in PRESENT.
- FLUSH (1 cycle):
  - srt_reset = 1, timeout_err = 1, no result produced; go to IDLE.
  - The rr pointer is already advanced, so the failed requester loses priority.
- res_chk = 1 only if both hold:
  - popcount(res_data) == popcount(captured word);
  - res_data has the form 1...10...0 (no 0 above a 1). The all-0 and all-1 words are valid.
- Arbitration examines req only in IDLE. A req deasserted before gnt is simply not granted.
- Latency from req to gnt: 2 cycles when idle (IDLE decision, then LOAD).
- Latency from LOAD to res_valid: W VO cycles + 1.
- Throughput: each new job needs LOAD plus at least one IDLE cycle.
- Reset mid-job aborts the job without a result or timeout_err. gnt pulses already issued stand.

Decomposition:
- Shared package `sorter_pkg`:
  - state enum (IDLE, LOAD, COLLECT, PRESENT, FLUSH);
  - SORT_W = 8;
  - function is_sorted_ones_first(word);
  - function popcount(word).
- One sub-module `rr_arbiter` (NREQ): inputs req, ptr; outputs one-hot grant and encoded id; combinational.
- The FSM, deserializer, watchdog and checker stay in sorter_sched.

Test Plan:
- Single job: req[0] with word 8'b01010101; model sorter emits 1,1,1,1,0,0,0,0 with VO.
  - gnt[0] 2 cycles after req; srt_ld pulses with srt_in = 8'h55.
  - res_data = 8'hF0, res_id = 0, res_chk = 1.
- Round-robin: req = 4'b1111 held continuously.
  - Grants occur in order 0, 1, 2, 3, 0.
  - Each result carries the matching res_id.
- Backpressure: res_ready held 0 for 5 cycles after res_valid.
  - res_valid/res_data stay stable; busy = 1; no gnt issued.
  - Accept on cycle 6 -> IDLE.
- Bad sorter: model returns 8'b10100000 for input 8'h55 -> res_chk = 0 (popcount 2 != 4).
- Timeout: model emits 3 VO bits, then none.
  - After 16 idle cycles: timeout_err and srt_reset pulse once; no res_valid.
  - Next req is serviced normally.
- Async reset asserted during COLLECT at bit 4.
  - All outputs 0 immediately; srt_reset = 1 during reset.
  - After release, busy = 0 and the rr pointer = 0.

Source files
------------

// File: rtl/sorter_pkg.sv
// Shared types and helpers for the sorter scheduler: FSM state encoding,
// sorter word width, and the result-check functions.
package sorter_pkg;

    localparam int SORT_W = 8;
    localparam int CNT_W  = $clog2(SORT_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COLLECT,
        PRESENT,
        FLUSH
    } state_t;

    // Number of set bits in a sorter word.
    function automatic logic [CNT_W-1:0] popcount(input logic [SORT_W-1:0] word);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < SORT_W; i++) begin
            cnt = cnt + CNT_W'(word[i]);
        end
        return cnt;
    endfunction

    // True when the word is all ones above all zeros (1...10...0).
    // The all-zero and all-one words qualify.
    function automatic logic is_sorted_ones_first(input logic [SORT_W-1:0] word);
        logic seen_zero;
        logic ok;
        seen_zero = 1'b0;
        ok        = 1'b1;
        for (int i = SORT_W - 1; i >= 0; i--) begin
            if (!word[i]) begin
                seen_zero = 1'b1;
            end else if (seen_zero) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping from NREQ-1 back to 0.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] id
);

    localparam int IDW = $clog2(NREQ);

    int   idx;
    logic found;

    // Scan from the pointer so the most recently served requester goes last.
    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                id         = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/sorter_sched.sv
// Round-robin front end for a single shared bit-serial sorter: loads one
// requester's word, deserialises the VO-qualified result, checks it and
// hands it back on a valid/ready interface. A watchdog aborts stalled jobs.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | arbitrate requests, capture winner id and word
//   LOAD    | pulse srt_ld and gnt, advance the round-robin pointer
//   COLLECT | shift in VO-qualified bits, watchdog runs on idle cycles
//   PRESENT | hold result until res_ready
//   FLUSH   | watchdog expired: reset the sorter, flag timeout_err
module sorter_sched
    import sorter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = SORT_W,
    parameter int TIMEOUT = 16
) (
    input  logic                    ck,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*W-1:0]       req_data,
    output logic [NREQ-1:0]         gnt,
    output logic [W-1:0]            srt_in,
    output logic                    srt_ld,
    output logic                    srt_reset,
    input  logic                    srt_vo,
    input  logic                    srt_out,
    output logic                    res_valid,
    output logic [W-1:0]            res_data,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic                    res_chk,
    input  logic                    res_ready,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int IDW  = $clog2(NREQ);
    localparam int BCW  = $clog2(W + 1);
    localparam int WDW  = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   id_q;
    logic [NREQ-1:0]  gnt_q;
    logic [W-1:0]     word_q;
    logic [BCW-1:0]   bit_cnt_q;
    logic [W-1:0]     shreg_q;
    logic [WDW-1:0]   wdog_q;

    logic [NREQ-1:0]  arb_grant;
    logic [IDW-1:0]   arb_id;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .id    (arb_id)
    );

    // Next state and all outputs; every output is a decode of registered state
    // except srt_reset, which also follows the async reset input directly.
    always_comb begin
        state_d     = state_q;
        gnt         = '0;
        srt_in      = word_q;
        srt_ld      = 1'b0;
        srt_reset   = reset;
        res_valid   = 1'b0;
        res_data    = shreg_q;
        res_id      = id_q;
        res_chk     = 1'b0;
        busy        = (state_q != IDLE);
        timeout_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) state_d = LOAD;
            end
            LOAD: begin
                gnt     = gnt_q;
                srt_ld  = 1'b1;
                state_d = COLLECT;
            end
            COLLECT: begin
                if (srt_vo) begin
                    if (bit_cnt_q == BCW'(W - 1)) state_d = PRESENT;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    state_d = FLUSH;
                end
            end
            PRESENT: begin
                res_valid = 1'b1;
                res_chk   = (popcount(shreg_q) == popcount(word_q))
                            && is_sorted_ones_first(shreg_q);
                if (res_ready) state_d = IDLE;
            end
            FLUSH: begin
                srt_reset   = 1'b1;
                timeout_err = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus capture, pointer, deserialiser and watchdog updates.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            gnt_q     <= '0;
            word_q    <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            wdog_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        id_q   <= arb_id;
                        gnt_q  <= arb_grant;
                        word_q <= req_data[int'(arb_id)*W +: W];
                    end
                end
                LOAD: begin
                    // Advance now so a job that later times out still loses priority.
                    rr_ptr_q  <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                    bit_cnt_q <= '0;
                    wdog_q    <= '0;
                    shreg_q   <= '0;
                end
                COLLECT: begin
                    if (srt_vo) begin
                        shreg_q   <= {shreg_q[W-2:0], srt_out};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        wdog_q    <= '0;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sorter_sched.sv
// Bench for sorter_sched with a behavioural bit-serial sorter model and a
// scoreboard of expected grants and results.
module tb_sorter_sched;

    localparam int NREQ    = 4;
    localparam int W       = 8;
    localparam int TIMEOUT = 16;

    logic              ck = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      srt_in;
    logic              srt_ld;
    logic              srt_reset;
    logic              srt_vo;
    logic              srt_out;
    logic              res_valid;
    logic [W-1:0]      res_data;
    logic [1:0]        res_id;
    logic              res_chk;
    logic              res_ready;
    logic              busy;
    logic              timeout_err;

    sorter_sched #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .ck          (ck),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .srt_in      (srt_in),
        .srt_ld      (srt_ld),
        .srt_reset   (srt_reset),
        .srt_vo      (srt_vo),
        .srt_out     (srt_out),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_id      (res_id),
        .res_chk     (res_chk),
        .res_ready   (res_ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 ck = ~ck;

    typedef struct packed {
        logic [2:0] id;
        logic [7:0] data;
        logic       chk;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   mode  = 0;     // sorter model: 0 correct, 1 broken output, 2 stalls after 3 bits
    int   gnt_seen = 0;
    int   tmo_seen = 0;
    int   srst_seen = 0;
    int   rv_cycles = 0;
    exp_t sb_q[$];
    int   exp_gnt_q[$];
    logic bit_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // What the sorter should return for word x in the given model mode.
    function automatic logic [7:0] model_word(input logic [7:0] x, input int m);
        logic [7:0] mask;
        int c;
        c = 0;
        for (int i = 0; i < 8; i++) c += int'(x[i]);
        if (m == 1) return 8'b1010_0000;
        mask = 8'hFF;
        mask = ~(mask >> c);
        return mask;
    endfunction

    // Bit-serial sorter model: one VO bit per cycle starting the cycle after ld.
    initial begin
        logic [7:0] w;
        int n;
        srt_vo  = 1'b0;
        srt_out = 1'b0;
        forever begin
            @(negedge ck);
            if (reset) begin
                bit_q.delete();
                srt_vo  = 1'b0;
                srt_out = 1'b0;
            end else if (srt_ld) begin
                bit_q.delete();
                w = model_word(srt_in, mode);
                n = (mode == 2) ? 3 : W;
                for (int i = 0; i < n; i++) bit_q.push_back(w[W-1-i]);
                srt_vo = 1'b0;
            end else if (bit_q.size() > 0) begin
                srt_vo  = 1'b1;
                srt_out = bit_q.pop_front();
            end else begin
                srt_vo  = 1'b0;
                srt_out = 1'b0;
            end
        end
    end

    // Grant monitor: checks grant order and queues the expected result.
    initial begin
        int e;
        exp_t x;
        forever begin
            @(negedge ck);
            if (!reset && gnt != '0) begin
                gnt_seen++;
                if (exp_gnt_q.size() == 0) begin
                    chk("gnt_unexp", 32'(gnt), 32'd0);
                end else begin
                    e = exp_gnt_q.pop_front();
                    chk("gnt_onehot", 32'(gnt), 32'(1 << e));
                    chk("gnt_ld", 32'(srt_ld), 32'd1);
                    chk("gnt_word", 32'(srt_in), 32'(req_data[e*W +: W]));
                    if (mode != 2) begin
                        x.id   = 3'(e);
                        x.data = model_word(req_data[e*W +: W], mode);
                        x.chk  = (mode == 0);
                        sb_q.push_back(x);
                    end
                end
            end
        end
    end

    // Result monitor: compares each accepted result with the scoreboard.
    initial begin
        exp_t x;
        forever begin
            @(negedge ck);
            if (!reset && res_valid && res_ready) begin
                if (sb_q.size() == 0) begin
                    chk("res_unexp", 32'(res_valid), 32'd0);
                end else begin
                    x = sb_q.pop_front();
                    chk("res_data", 32'(res_data), 32'(x.data));
                    chk("res_id", 32'(res_id), 32'(x.id));
                    chk("res_chk", 32'(res_chk), 32'(x.chk));
                end
            end
        end
    end

    // Pulse counters outside of reset.
    initial begin
        forever begin
            @(negedge ck);
            if (!reset) begin
                if (timeout_err) tmo_seen++;
                if (srt_reset) srst_seen++;
                if (res_valid) rv_cycles++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    task automatic wait_gnt(input int target, input int max, input string tag);
        int k;
        k = 0;
        while (gnt_seen < target && k < max) begin
            @(negedge ck);
            #1;
            k++;
        end
        chk(tag, 32'(gnt_seen >= target), 32'd1);
        @(posedge ck);
        #1;
    endtask

    task automatic wait_idle(input int max, input string tag);
        int k;
        k = 0;
        while ((busy || sb_q.size() != 0) && k < max) begin
            @(negedge ck);
            #1;
            k++;
        end
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
        @(posedge ck);
        #1;
    endtask

    initial begin
        int k;
        int t0, s0, r0;
        reset     = 1'b1;
        req       = '0;
        req_data  = '0;
        res_ready = 1'b1;

        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ld", 32'(srt_ld), 32'd0);
        chk("rst_srt_in", 32'(srt_in), 32'd0);
        chk("rst_srt_reset", 32'(srt_reset), 32'd1);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        tick(1);
        reset = 1'b0;

        // Single job: 2-cycle grant latency, W+1 cycles from LOAD to result.
        req_data = {8'h00, 8'h00, 8'h00, 8'h55};
        exp_gnt_q.push_back(0);
        req = 4'b0001;
        @(negedge ck); #1;
        chk("lat_gnt_c1", 32'(gnt), 32'd0);
        @(negedge ck); #1;
        chk("lat_gnt_c2", 32'(gnt), 32'd1);
        chk("ld_pulse", 32'(srt_ld), 32'd1);
        chk("ld_word", 32'(srt_in), 32'h55);
        @(posedge ck); #1;
        req = '0;
        k = 1;
        @(negedge ck); #1;
        while (!res_valid && k < 20) begin
            @(negedge ck); #1;
            k++;
        end
        chk("lat_res", 32'(k), 32'd9);
        wait_idle(40, "single");

        // Round robin from pointer 0 with every request held.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        req_data = {8'h00, 8'hFF, 8'h81, 8'h0F};
        for (int i = 0; i < 5; i++) exp_gnt_q.push_back(i % NREQ);
        req = 4'b1111;
        wait_gnt(gnt_seen + 5, 200, "rr_gnts");
        req = '0;
        wait_idle(40, "rr");

        // Backpressure: result held for 5 cycles, no new grant meanwhile.
        req_data = {8'h00, 8'hE7, 8'h3C, 8'h00};
        exp_gnt_q.push_back(1);
        res_ready = 1'b0;
        req = 4'b0010;
        wait_gnt(gnt_seen + 1, 50, "bp_gnt");
        req = '0;
        k = 0;
        while (!res_valid && k < 30) begin
            @(negedge ck); #1;
            k++;
        end
        chk("bp_valid_seen", 32'(res_valid), 32'd1);
        exp_gnt_q.push_back(2);
        req = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_data", 32'(res_data), 32'hF0);
            chk("bp_id", 32'(res_id), 32'd1);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_no_gnt", 32'(gnt), 32'd0);
            if (i < 4) begin
                @(negedge ck); #1;
            end
        end
        @(posedge ck); #1;
        res_ready = 1'b1;
        wait_gnt(gnt_seen + 1, 50, "bp_next_gnt");
        req = '0;
        wait_idle(40, "bp");

        // Broken sorter output: popcount mismatch must clear res_chk.
        mode = 1;
        req_data = {8'h55, 8'h00, 8'h00, 8'h00};
        exp_gnt_q.push_back(3);
        req = 4'b1000;
        wait_gnt(gnt_seen + 1, 50, "bad_gnt");
        req = '0;
        wait_idle(40, "bad");
        mode = 0;

        // Stalled sorter: 3 bits then silence, watchdog aborts.
        mode = 2;
        t0 = tmo_seen;
        s0 = srst_seen;
        r0 = rv_cycles;
        req_data = {8'h00, 8'h00, 8'hC3, 8'h55};
        exp_gnt_q.push_back(0);
        req = 4'b0001;
        wait_gnt(gnt_seen + 1, 50, "tmo_gnt");
        req = '0;
        k = 0;
        do begin
            @(negedge ck); #1;
            k++;
        end while (!timeout_err && k < 60);
        chk("tmo_lat", 32'(k), 32'd20);
        chk("tmo_srst", 32'(srt_reset), 32'd1);
        tick(5);
        chk("tmo_pulses", 32'(tmo_seen - t0), 32'd1);
        chk("tmo_srst_pulses", 32'(srst_seen - s0), 32'd1);
        chk("tmo_no_result", 32'(rv_cycles - r0), 32'd0);
        chk("tmo_idle", 32'(busy), 32'd0);
        mode = 0;
        exp_gnt_q.push_back(1);
        req = 4'b0010;
        wait_gnt(gnt_seen + 1, 50, "post_tmo_gnt");
        req = '0;
        wait_idle(40, "post_tmo");

        // Async reset in the middle of collection.
        req_data = {8'h00, 8'h5A, 8'h00, 8'h00};
        exp_gnt_q.push_back(2);
        req = 4'b0100;
        wait_gnt(gnt_seen + 1, 50, "ar_gnt");
        req = '0;
        repeat (4) @(negedge ck);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_valid", 32'(res_valid), 32'd0);
        chk("ar_gnt", 32'(gnt), 32'd0);
        chk("ar_ld", 32'(srt_ld), 32'd0);
        chk("ar_srt_in", 32'(srt_in), 32'd0);
        chk("ar_data", 32'(res_data), 32'd0);
        chk("ar_tmo", 32'(timeout_err), 32'd0);
        chk("ar_srt_reset", 32'(srt_reset), 32'd1);
        sb_q.delete();
        tick(2);
        reset = 1'b0;
        #1;
        chk("ar_rel_srst", 32'(srt_reset), 32'd0);
        chk("ar_rel_busy", 32'(busy), 32'd0);
        req_data = {8'h01, 8'h02, 8'h04, 8'h80};
        exp_gnt_q.push_back(0);
        req = 4'b1111;
        wait_gnt(gnt_seen + 1, 50, "ar_ptr0_gnt");
        req = '0;
        wait_idle(40, "ar_post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
